// File: rtl/nibble_pkg.sv
// nibble_pkg: definitions shared by the nibble-serial add/sub engine.
//   NIB_W      - width of one processing slice, in bits
//   state_t    - control states of the serial adder
//   idx_width  - width of the nibble index counter for a given operand width
package nibble_pkg;

   localparam int NIB_W = 4;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // clog2 of the nibble count, never narrower than one bit so that the
   // single-nibble configuration still has a legal counter.
   function automatic int idx_width(input int width);
      int n;
      n = width / NIB_W;
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/nibble_add4.sv
// nibble_add4: combinational nibble adder with carry in.
//   a, b : nibble operands
//   cin  : carry in
//   nib  : {carry out, nibble sum}
module nibble_add4
   import nibble_pkg::*;
(
   input  logic [NIB_W-1:0] a,
   input  logic [NIB_W-1:0] b,
   input  logic             cin,
   output logic [NIB_W:0]   nib
);

   assign nib = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, cin};

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit add/subtract processed one nibble per clock,
// least significant nibble first, with the carry held in a register.
//   clk, rst : clock and synchronous active-high reset
//   start    : request, accepted only while idle (A, B, mode latched then)
//   mode     : 0 = A+B, 1 = A-B
//   A, B     : operands
//   sum      : result, valid with done and held until the next accepted start
//   cout     : carry out for add, no-borrow (A >= B unsigned) for subtract
//   ovf      : two's-complement overflow
//   busy     : high for the WIDTH/4 cycles in which nibbles are processed
//   done     : one-cycle pulse when sum/cout/ovf are valid
//   state    : current control state, for observation
//
// Handshake: a start seen at a rising edge while state is IDLE is accepted;
// busy is high for exactly N cycles after that edge and done is high for the
// single cycle that follows. Since done is raised while already IDLE, a start
// held in the done cycle is accepted, giving one op every N+1 cycles.
module nibble_serial_adder
   import nibble_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy,
   output logic             done,
   output state_t           state
);

   localparam int N  = WIDTH / NIB_W;
   localparam int IW = idx_width(WIDTH);

   state_t           state_next;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] bx_q;   // B, already inverted for subtract
   logic             carry_q;
   logic [IW-1:0]    idx_q;
   logic [NIB_W-1:0] a_nib;
   logic [NIB_W-1:0] b_nib;
   logic [NIB_W:0]   nib;
   logic             last;

   assign last = (idx_q == IW'(N - 1));
   assign busy = (state == RUN);

   // Select the nibble pair addressed by the index for the shared adder.
   always_comb begin
      a_nib = '0;
      b_nib = '0;
      for (int i = 0; i < N; i++) begin
         if (idx_q == IW'(i)) begin
            a_nib = a_q[i*NIB_W +: NIB_W];
            b_nib = bx_q[i*NIB_W +: NIB_W];
         end
      end
   end

   nibble_add4 u_add (
      .a   (a_nib),
      .b   (b_nib),
      .cin (carry_q),
      .nib (nib)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last)  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         bx_q    <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         sum     <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  a_q     <= A;
                  // Subtract as A + ~B + 1: the +1 enters as the initial carry.
                  bx_q    <= mode ? ~B : B;
                  carry_q <= mode;
                  idx_q   <= '0;
               end
            end
            RUN: begin
               for (int i = 0; i < N; i++) begin
                  if (idx_q == IW'(i)) sum[i*NIB_W +: NIB_W] <= nib[NIB_W-1:0];
               end
               carry_q <= nib[NIB_W];
               if (last) begin
                  cout  <= nib[NIB_W];
                  // Operands of equal sign whose result sign differs.
                  ovf   <= (a_q[WIDTH-1] == bx_q[WIDTH-1]) &&
                           (nib[NIB_W-1] != a_q[WIDTH-1]);
                  done  <= 1'b1;
                  idx_q <= '0;
               end else begin
                  idx_q <= idx_q + IW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;
   import nibble_pkg::*;

   localparam int W = 16;
   localparam int N = W / 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   longint cyc = 0;
   always @(posedge clk) cyc++;

   // ---------------- 16-bit DUT ----------------
   logic         start = 1'b0, mode = 1'b0;
   logic [W-1:0] A = '0, B = '0;
   logic [W-1:0] sum;
   logic         cout, ovf, busy, done;
   state_t       state;

   nibble_serial_adder #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .A(A), .B(B),
      .sum(sum), .cout(cout), .ovf(ovf), .busy(busy), .done(done), .state(state)
   );

   // ---------------- 8-bit DUT ----------------
   logic       start8 = 1'b0, mode8 = 1'b0;
   logic [7:0] A8 = '0, B8 = '0;
   logic [7:0] sum8;
   logic       cout8, ovf8, busy8, done8;
   state_t     state8;

   nibble_serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .mode(mode8), .A(A8), .B(B8),
      .sum(sum8), .cout(cout8), .ovf(ovf8), .busy(busy8), .done(done8), .state(state8)
   );

   // ---------------- 4-bit DUT ----------------
   logic       start4 = 1'b0, mode4 = 1'b0;
   logic [3:0] A4 = '0, B4 = '0;
   logic [3:0] sum4;
   logic       cout4, ovf4, busy4, done4;
   state_t     state4;

   nibble_serial_adder #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .mode(mode4), .A(A4), .B(B4),
      .sum(sum4), .cout(cout4), .ovf(ovf4), .busy(busy4), .done(done4), .state(state4)
   );

   // ---------------- scoreboard state ----------------
   int           n_cmp = 0;
   int           n_err = 0;
   int           issued = 0;
   int           done_cnt = 0;
   logic [W+1:0] exp_q[$];   // {sum, cout, ovf}

   function automatic void check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic void timeout_fail(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
   endfunction

   // Reference model in plain integer arithmetic on w-bit values.
   function automatic void ref_model(input int w, input longint a, input longint b,
                                     input bit m, output longint s, output bit c,
                                     output bit o);
      longint md, half, sa, sb, r;
      md   = longint'(1) << w;
      half = md / 2;
      if (!m) begin
         s = (a + b) % md;
         c = ((a + b) >= md);
      end else begin
         s = (a - b + md) % md;
         c = (a >= b);
      end
      sa = (a >= half) ? a - md : a;
      sb = (b >= half) ? b - md : b;
      r  = m ? sa - sb : sa + sb;
      o  = (r < -half) || (r >= half);
   endfunction

   // ---------------- monitor (16-bit) ----------------
   int busy_cnt = 0;
   always @(negedge clk) begin
      logic [W+1:0] e;
      if (rst) begin
         busy_cnt = 0;
      end else begin
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            check("busy_len", busy_cnt, N);
            check("busy_at_done", busy, 0);
            busy_cnt = 0;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_done: got done=1 expected no result pending (t=%0t)", $time);
            end else begin
               e = exp_q.pop_front();
               check("sum",  sum,  e[W+1:2]);
               check("cout", cout, e[1]);
               check("ovf",  ovf,  e[0]);
            end
         end
      end
   end

   // ---------------- driver (16-bit) ----------------
   bit     prev_hold = 1'b0;
   longint last_acc  = 0;

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                        input bit hold, input bit push);
      int     t;
      longint s;
      bit     c, o;
      t = 0;
      @(negedge clk);
      while (busy && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) timeout_fail("idle_wait");
      A = a;
      B = b;
      mode = m;
      start = 1'b1;
      @(posedge clk);
      #1;
      if (prev_hold) check("b2b_gap", cyc - last_acc, N + 1);
      last_acc  = cyc;
      prev_hold = hold;
      if (push) begin
         ref_model(W, longint'(a), longint'(b), m, s, c, o);
         exp_q.push_back({s[W-1:0], c, o});
         issued++;
      end
      if (!hold) start = 1'b0;
   endtask

   // ---------------- drivers (small widths) ----------------
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic m);
      int     t, bc;
      longint s;
      bit     c, o;
      t = 0;
      bc = 0;
      @(negedge clk);
      A8 = a; B8 = b; mode8 = m; start8 = 1'b1;
      @(posedge clk);
      #1 start8 = 1'b0;
      do begin
         @(negedge clk);
         if (busy8) bc++;
         t++;
      end while (!done8 && t < 20);
      check("w8_done_seen", done8, 1);
      ref_model(8, longint'(a), longint'(b), m, s, c, o);
      check("w8_sum",  sum8,  s);
      check("w8_cout", cout8, c);
      check("w8_ovf",  ovf8,  o);
      check("w8_busy_len", bc, 2);
   endtask

   task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic m);
      int     t, bc;
      longint s;
      bit     c, o;
      t = 0;
      bc = 0;
      @(negedge clk);
      A4 = a; B4 = b; mode4 = m; start4 = 1'b1;
      @(posedge clk);
      #1 start4 = 1'b0;
      do begin
         @(negedge clk);
         if (busy4) bc++;
         t++;
      end while (!done4 && t < 20);
      check("w4_done_seen", done4, 1);
      ref_model(4, longint'(a), longint'(b), m, s, c, o);
      check("w4_sum",  sum4,  s);
      check("w4_cout", cout4, c);
      check("w4_ovf",  ovf4,  o);
      check("w4_busy_len", bc, 1);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int t;

      // Reset values
      repeat (2) @(negedge clk);
      check("rst_sum",  sum,  0);
      check("rst_cout", cout, 0);
      check("rst_ovf",  ovf,  0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_busy8", busy8, 0);
      check("rst_sum4", sum4, 0);
      rst = 1'b0;

      // Directed add / subtract cases
      issue(16'h1234, 16'h8181, 1'b0, 1'b0, 1'b1);
      issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
      issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
      issue(16'h0100, 16'h0001, 1'b1, 1'b0, 1'b1);
      issue(16'h0000, 16'h0001, 1'b1, 1'b0, 1'b1);
      issue(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b1);

      // Start and operand changes during RUN are ignored
      issue(16'h0AAA, 16'h0555, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      @(negedge clk);
      start = 1'b1;
      A = 16'($urandom);
      B = 16'($urandom);
      mode = 1'b1;
      @(negedge clk);
      start = 1'b0;

      // Reset in the middle of an operation aborts it
      issue(16'h4321, 16'h1111, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_busy",  busy, 0);
      check("abort_sum",   sum,  0);
      check("abort_done",  done, 0);
      check("abort_cout",  cout, 0);
      check("abort_ovf",   ovf,  0);
      check("abort_state", state, IDLE);
      rst = 1'b0;
      issue(16'h0009, 16'h0063, 1'b0, 1'b0, 1'b1);

      // Start held high, new operands presented in each done cycle
      for (int i = 0; i < 6; i++)
         issue(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), (i < 5), 1'b1);

      // Random traffic, including boundary operands
      for (int i = 0; i < 30; i++) begin
         logic [W-1:0] ra, rb;
         ra = 16'($urandom);
         rb = 16'($urandom);
         case ($urandom_range(0, 5))
            0: ra = 16'hFFFF;
            1: rb = 16'h0000;
            2: ra = 16'h8000;
            3: rb = 16'h7FFF;
            default: ;
         endcase
         issue(ra, rb, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
      end

      // Drain
      t = 0;
      while ((exp_q.size() != 0 || busy) && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) timeout_fail("drain");
      repeat (3) @(negedge clk);

      // Narrow configurations
      op8(8'hED, 8'h8C, 1'b0);
      for (int i = 0; i < 6; i++)
         op8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      op4(4'hD, 4'hD, 1'b0);
      for (int i = 0; i < 6; i++)
         op4(4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));

      check("done_count", done_cnt, issued);
      check("queue_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
